// File: rtl/b08_sched_pkg.sv
// b08_sched_pkg: shared types and constants for the b08 round-robin scheduler.
// Contents: FSM state enum, operand/result widths, counter width helper.
package b08_sched_pkg;

  localparam int unsigned OpW  = 8;
  localparam int unsigned ResW = 4;

  typedef enum logic [2:0] {
    StIdle,
    StFlush,
    StLaunch,
    StRun,
    StDone
  } sched_state_e;

  // Wide enough to hold max(a, b) - 1 with headroom; the counter only
  // ever loads a value below its width limit and stops at zero.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
// Ports:
//   req_i        - per-requester request levels
//   ptr_i        - highest-priority index; search runs upward from here with wrap
//   gnt_onehot_o - one-hot winner (all zero when no request)
//   gnt_idx_o    - binary winner index (zero when no request)
//   gnt_valid_o  - at least one request is present
module rr_arbiter #(
  parameter  int unsigned N    = 4,
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_onehot_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            gnt_valid_o
);

  always_comb begin
    int unsigned     idx;
    logic [IdxW-1:0] sel;
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    gnt_valid_o  = 1'b0;
    idx          = 0;
    sel          = '0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = 32'(ptr_i) + off;
      if (idx >= N) idx = idx - N;
      sel = IdxW'(idx);
      if (!gnt_valid_o && req_i[sel]) begin
        gnt_valid_o       = 1'b1;
        gnt_idx_o         = sel;
        gnt_onehot_o[sel] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/b08_sched.sv
// b08_sched: round-robin scheduler sharing one b08 pattern-matcher core.
// Ports:
//   clk_i, rst_i    - clock, synchronous active-high reset
//   req_i, data_i   - per-requester request levels and 8-bit operands
//   ack_o           - one-hot, one-cycle pulse to the served requester
//   result_o        - captured core output, result_valid_o pulses with ack_o
//   busy_o          - high whenever a job is in flight
//   core_reset_o, core_start_o, core_i_o - drive the b08 core
//   core_o_i        - b08 core output
module b08_sched
  import b08_sched_pkg::*;
#(
  parameter int unsigned NReq      = 4,
  parameter int unsigned StartHold = 2,
  parameter int unsigned CoreLat   = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NReq-1:0]      req_i,
  input  logic [NReq*OpW-1:0]  data_i,
  output logic [NReq-1:0]      ack_o,
  output logic [ResW-1:0]      result_o,
  output logic                 result_valid_o,
  output logic                 busy_o,
  output logic                 core_reset_o,
  output logic                 core_start_o,
  output logic [OpW-1:0]       core_i_o,
  input  logic [ResW-1:0]      core_o_i
);

  localparam int unsigned IdxW = $clog2(NReq);
  localparam int unsigned CntW = cnt_width(StartHold, CoreLat);

  sched_state_e    state_q;
  logic [IdxW-1:0] ptr_q, gidx_q;
  logic [NReq-1:0] gnt_oh_q, ack_q;
  logic [OpW-1:0]  op_q;
  logic [CntW-1:0] cnt_q;
  logic [ResW-1:0] result_q;
  logic            valid_q;

  logic [NReq-1:0] gnt_onehot;
  logic [IdxW-1:0] gnt_idx;
  logic            gnt_valid;
  logic [OpW-1:0]  op_sel;

  rr_arbiter #(
    .N (NReq)
  ) u_arb (
    .req_i        (req_i),
    .ptr_i        (ptr_q),
    .gnt_onehot_o (gnt_onehot),
    .gnt_idx_o    (gnt_idx),
    .gnt_valid_o  (gnt_valid)
  );

  // Operand byte of the current arbitration winner.
  always_comb begin
    op_sel = '0;
    for (int unsigned i = 0; i < NReq; i++) begin
      if (gnt_idx == IdxW'(i)) op_sel = data_i[i*OpW +: OpW];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      gidx_q   <= '0;
      gnt_oh_q <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ack_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            gidx_q   <= gnt_idx;
            gnt_oh_q <= gnt_onehot;
            op_q     <= op_sel;
            state_q  <= StFlush;
          end
        end
        StFlush: begin
          cnt_q   <= CntW'(StartHold - 1);
          state_q <= StLaunch;
        end
        StLaunch: begin
          if (cnt_q == '0) begin
            cnt_q   <= CntW'(CoreLat - 1);
            state_q <= StRun;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StRun: begin
          if (cnt_q == '0) begin
            result_q <= core_o_i;
            ack_q    <= gnt_oh_q;
            valid_q  <= 1'b1;
            state_q  <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          ack_q   <= '0;
          valid_q <= 1'b0;
          // The served requester drops to lowest priority next round.
          ptr_q   <= (gidx_q == IdxW'(NReq - 1)) ? '0 : gidx_q + 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack_o          = ack_q;
  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign busy_o         = (state_q != StIdle);
  assign core_start_o   = (state_q == StLaunch);
  assign core_i_o       = op_q;
  // Core reset follows the block reset combinationally so the core is held
  // in reset for exactly as long as the scheduler.
  assign core_reset_o   = rst_i | (state_q == StFlush);

endmodule

// File: tb/tb_b08_sched.sv
// tb_b08_sched: self-checking bench for b08_sched with a scoreboard of
// expected acknowledges and results, plus a small-parameter instance.
module tb_b08_sched;

  typedef struct {
    logic [3:0] ack;
    logic [3:0] res;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req;
  logic [31:0] data;
  logic [3:0]  ack, result, core_o;
  logic        result_valid, busy, core_reset, core_start;
  logic [7:0]  core_i;
  logic        seen;

  logic [1:0]  s_req;
  logic [15:0] s_data;
  logic [1:0]  s_ack;
  logic [3:0]  s_result, s_core_o;
  logic        s_valid, s_busy, s_core_reset, s_core_start, s_seen;
  logic [7:0]  s_core_i;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  exp_t        sb_q[$];

  b08_sched #(.NReq(4), .StartHold(2), .CoreLat(12)) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .data_i         (data),
    .ack_o          (ack),
    .result_o       (result),
    .result_valid_o (result_valid),
    .busy_o         (busy),
    .core_reset_o   (core_reset),
    .core_start_o   (core_start),
    .core_i_o       (core_i),
    .core_o_i       (core_o)
  );

  b08_sched #(.NReq(2), .StartHold(1), .CoreLat(1)) u_small (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (s_req),
    .data_i         (s_data),
    .ack_o          (s_ack),
    .result_o       (s_result),
    .result_valid_o (s_valid),
    .busy_o         (s_busy),
    .core_reset_o   (s_core_reset),
    .core_start_o   (s_core_start),
    .core_i_o       (s_core_i),
    .core_o_i       (s_core_o)
  );

  function automatic logic [3:0] model_f(input logic [7:0] x);
    return x[7:4] ^ x[3:0] ^ 4'h6;
  endfunction

  // Behavioural core: output stays zero until START has been seen.
  always @(posedge clk) begin
    if (core_reset) begin
      core_o <= 4'h0;
      seen   <= 1'b0;
    end else begin
      if (core_start) seen <= 1'b1;
      core_o <= (core_start || seen) ? model_f(core_i) : 4'h0;
    end
  end

  always @(posedge clk) begin
    if (s_core_reset) begin
      s_core_o <= 4'h0;
      s_seen   <= 1'b0;
    end else begin
      if (s_core_start) s_seen <= 1'b1;
      s_core_o <= (s_core_start || s_seen) ? model_f(s_core_i) : 4'h0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard monitor for the default instance.
  always @(negedge clk) begin
    if (!rst && (ack != 4'h0 || result_valid)) begin
      exp_t e;
      if (sb_q.size() == 0) begin
        check_eq("unexpected_ack", 32'(ack), 32'h0);
      end else begin
        e = sb_q.pop_front();
        check_eq("sb_ack", 32'(ack), 32'(e.ack));
        check_eq("sb_result", 32'(result), 32'(e.res));
        check_eq("sb_valid", 32'(result_valid), 32'h1);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ack(input string tag, input int budget);
    bit got;
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      @(negedge clk);
      if (ack != 4'h0) got = 1'b1;
    end
    check_eq(tag, 32'(got), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int last;
    rst    = 1'b1;
    req    = '0;
    data   = '0;
    s_req  = '0;
    s_data = '0;
    step(2);

    // Reset state
    check_eq("rst_ack", 32'(ack), 32'h0);
    check_eq("rst_valid", 32'(result_valid), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_start", 32'(core_start), 32'h0);
    check_eq("rst_core_i", 32'(core_i), 32'h0);
    check_eq("rst_result", 32'(result), 32'h0);
    check_eq("rst_core_reset", 32'(core_reset), 32'h1);
    rst = 1'b0;
    step(1);
    check_eq("post_rst_core_reset", 32'(core_reset), 32'h0);

    // Single request: exact protocol timing relative to the grant edge
    req        = 4'b0001;
    data[7:0]  = 8'hA5;
    sb_q.push_back('{ack: 4'b0001, res: 4'h9});
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req = 4'b0000;
        check_eq("t1_core_i", 32'(core_i), 32'hA5);
      end
      check_eq($sformatf("t1_core_reset_k%0d", k), 32'(core_reset), 32'(k == 0));
      check_eq($sformatf("t1_core_start_k%0d", k), 32'(core_start), 32'(k == 1 || k == 2));
      check_eq($sformatf("t1_busy_k%0d", k), 32'(busy), 32'(k <= 15));
      check_eq($sformatf("t1_ack_k%0d", k), 32'(ack), (k == 15) ? 32'h1 : 32'h0);
    end
    check_eq("t1_result_held", 32'(result), 32'h9);

    // All four requesting: reset so the pointer restarts at 0
    rst = 1'b1;
    step(1);
    rst  = 1'b0;
    data = 32'h08040201;
    step(1);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      int j;
      j = i % 4;
      sb_q.push_back('{ack: 4'(1 << j), res: model_f(8'(1 << j))});
    end
    n = 0;
    for (int c = 0; c < 120 && n < 5; c++) begin
      @(negedge clk);
      if (ack != 4'h0) begin
        n++;
        if (n == 5) req = 4'b0000;
      end
    end
    check_eq("t2_jobs", 32'(n), 32'd5);
    step(3);
    check_eq("t2_idle", 32'(busy), 32'h0);

    // Withdrawal: requester 2 appears during job 0 and leaves before IDLE
    req        = 4'b0001;
    data[7:0]  = 8'h10;
    sb_q.push_back('{ack: 4'b0001, res: model_f(8'h10)});
    step(1);
    check_eq("t3_busy", 32'(busy), 32'h1);
    req          = 4'b0100;
    data[23:16]  = 8'h33;
    step(10);
    req = 4'b0000;
    wait_ack("t3_ack_seen", 20);
    step(20);
    check_eq("t3_no_regrant", 32'(busy), 32'h0);

    // Post-grant drop: requester 1 drops its request during RUN
    req         = 4'b0010;
    data[15:8]  = 8'h3C;
    sb_q.push_back('{ack: 4'b0010, res: model_f(8'h3C)});
    step(1);
    step(8);
    req = 4'b0000;
    wait_ack("t4_ack_seen", 20);
    step(2);

    // Reset mid-RUN
    req        = 4'b0001;
    data[7:0]  = 8'hFF;
    step(1);
    req = 4'b0000;
    step(5);
    rst = 1'b1;
    step(1);
    check_eq("t5_ack", 32'(ack), 32'h0);
    check_eq("t5_valid", 32'(result_valid), 32'h0);
    check_eq("t5_busy", 32'(busy), 32'h0);
    check_eq("t5_start", 32'(core_start), 32'h0);
    check_eq("t5_core_i", 32'(core_i), 32'h0);
    check_eq("t5_result", 32'(result), 32'h0);
    check_eq("t5_core_reset", 32'(core_reset), 32'h1);
    rst = 1'b0;
    step(20);
    check_eq("t5_quiet", 32'(busy), 32'h0);
    // With ptr back at 0, requester 1 beats requester 3
    req          = 4'b1010;
    data[15:8]   = 8'h55;
    data[31:24]  = 8'h70;
    sb_q.push_back('{ack: 4'b0010, res: model_f(8'h55)});
    step(1);
    req = 4'b0000;
    wait_ack("t5_ack_seen", 20);
    step(2);

    // Parameter corner: NReq=2, StartHold=1, CoreLat=1
    s_data = 16'h0201;
    s_req  = 2'b11;
    n      = 0;
    last   = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (s_ack != 2'b00) begin
        check_eq($sformatf("t6_ack_%0d", n), 32'(s_ack), (n % 2 == 0) ? 32'h1 : 32'h2);
        check_eq($sformatf("t6_result_%0d", n), 32'(s_result),
                 32'(model_f((n % 2 == 0) ? 8'h01 : 8'h02)));
        check_eq($sformatf("t6_valid_%0d", n), 32'(s_valid), 32'h1);
        if (n > 0) check_eq($sformatf("t6_period_%0d", n), 32'(c - last), 32'd5);
        last = c;
        n++;
        if (n == 4) s_req = 2'b00;
      end
    end
    check_eq("t6_jobs", 32'(n), 32'd4);
    step(3);
    check_eq("t6_idle", 32'(s_busy), 32'h0);

    check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/b08_sched.md
# b08_sched

Round-robin scheduler that shares one `b08` pattern-matcher core among `NREQ` requesters. It latches the winning requester's 8-bit operand and sequences the core's `START` protocol, then waits a fixed core latency. It then captures the core's 4-bit `O` and returns it with a one-cycle acknowledge. It sits between the requester fabric and a single `b08` instance, and is the only driver of that core's `START`, `I` and `RESET`.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `START_HOLD`, 2: cycles `CORE_START` is held high per launch (≥1).
- `CORE_LAT`, 12: cycles from `CORE_START` falling to `CORE_O` being valid (≥1).
- `CLOCK` in 1: single clock; all logic is on the rising edge.
- `RESET` in 1: synchronous, active-high.
- `REQ` in NREQ: per-requester request level.
- `DATA` in NREQ*8: operands; requester k occupies bits [8k+7:8k].
- `ACK` out NREQ: one-hot, one-cycle pulse marking the requester whose `RESULT` is valid.
- `RESULT` out 4: captured core output.
- `RESULT_VALID` out 1: high in the same cycle as the `ACK` pulse.
- `BUSY` out 1: high in every state except IDLE.
- `CORE_RESET` out 1: drives the core reset.
- `CORE_START` out 1: drives the core `START`.
- `CORE_I` out 8: drives the core `I`.
- `CORE_O` in 4: core `O`.

## Operation
- States: IDLE, FLUSH, LAUNCH, RUN, DONE.
- IDLE:
  - If any `REQ` is high, the round-robin arbiter picks a winner, searching upward from `ptr` with wrap.
  - In the same edge: latch the winner index into `gidx`, latch its `DATA` byte into `op`, go to FLUSH.
  - Otherwise stay in IDLE.
- FLUSH, 1 cycle: `CORE_RESET`=1, which forces the core state to zero. Then go to LAUNCH.
- LAUNCH, `START_HOLD` cycles: `CORE_START`=1 and `CORE_I`=`op`. Then go to RUN.
- RUN, `CORE_LAT` cycles: `CORE_START`=0 and `CORE_I`=`op`. On the last RUN cycle, `RESULT` ← `CORE_O`. Then go to DONE.
- DONE, 1 cycle:
  - `ACK[gidx]`=1 and `RESULT_VALID`=1.
  - `ptr` ← (`gidx`+1) mod `NREQ`.
  - Go to IDLE.
- `CORE_I` is driven with `op` in every state, so it stays stable from FLUSH through DONE.
- `CORE_RESET` = `RESET` OR (state==FLUSH).
- Handshake rules:
  - A requester holds `REQ` and keeps `DATA` stable until it is granted.
  - Dropping `REQ` before the grant withdraws the request.
  - After the grant, `REQ` and `DATA` are ignored. `ACK` is still delivered to `gidx` even if `REQ` has dropped.
  - A requester that keeps `REQ` high after its `ACK` is eligible again in the next IDLE, but at lowest priority.
- Counter:
  - Width is clog2(max(`START_HOLD`,`CORE_LAT`))+1.
  - It loads on each state entry and decrements; the state exits when it reaches 0.
  - It never wraps.

## Timing
- Reset values: state=IDLE, `ptr`=0, `op`=0, `gidx`=0, `RESULT`=0, `RESULT_VALID`=0, `ACK`=0, `BUSY`=0, `CORE_START`=0, `CORE_I`=0, `CORE_RESET`=1 while `RESET` is high.
- Reset mid-operation: on the next edge everything returns to the reset values. No `ACK` is issued for the aborted job.
- Latency: `REQ` sampled high in IDLE at edge t gives `ACK` high during cycle t+1+1+`START_HOLD`+`CORE_LAT`. With the defaults that is 15 cycles after the sampling edge.
- Back-to-back: the earliest next grant is the edge at the end of the cycle after DONE, which is IDLE's first cycle. There is no combinational `REQ`→`ACK` path.
- Simultaneous requests: exactly one grant per job, chosen in round-robin order.

## Structure
- Package `b08_sched_pkg` holds:
  - the state enum (3-bit encoding);
  - `OP_W`=8 and `RES_W`=4;
  - a function computing counter width.
- Sub-module `rr_arbiter` is parameterized by `N`. It is purely combinational: inputs `req[N]` and `ptr`, outputs `gnt_onehot` and `gnt_idx`. The scheduler registers `ptr`.
- The `b08` core is instantiated by the parent, not inside this block.

## Test plan
- Single request, defaults:
  - Stimulus: `REQ`=0001, `DATA[7:0]`=8'hA5, with a behavioural core model returning `O`=4'h9.
  - Required: `CORE_RESET` pulses one cycle; `CORE_START` is high for 2 cycles; `ACK`=0001 and `RESULT`=9 exactly 15 cycles after the grant edge; `BUSY` drops the cycle after.
- All four requesting continuously:
  - Required: grant order is 0,1,2,3,0.
  - Required: each `RESULT` matches its own operand through the model (operands 8'h01, 8'h02, 8'h04, 8'h08).
- Withdrawal:
  - Stimulus: requester 2 raises `REQ` during job 0 and drops it before IDLE.
  - Required: no grant and no `ACK` to requester 2.
- Post-grant drop:
  - Stimulus: requester 1 drops `REQ` during RUN.
  - Required: `ACK[1]` is still pulsed with the correct `RESULT`.
- Reset mid-RUN:
  - Stimulus: `RESET` high for 1 cycle in RUN.
  - Required: all outputs return to their reset values; no `ACK`; the next job starts with `ptr`=0.
- Parameter corner:
  - Stimulus: `START_HOLD`=1, `CORE_LAT`=1, `NREQ`=2, with both requesting.
  - Required: each job lasts 5 cycles (IDLE, FLUSH, LAUNCH, RUN, DONE) and grants alternate 0,1,0,1.
